// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - 65C02 program counter sequencer: increment, branch, jump, vector fetch, push
module pc_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'hFFFC,
    parameter logic [15:0] NMI_VEC   = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC   = 16'hFFFE
) (
    input  logic        fclk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd,
    input  logic [1:0]  vec_sel,
    input  logic [7:0]  db_in,
    output logic        cmd_ready,
    output logic [15:0] pc,
    output logic [15:0] addr_out,
    output logic [7:0]  db_out,
    output logic        db_we,
    output logic        page_cross,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIX,
        S_JMP_HI,
        S_VEC_LO,
        S_VEC_HI,
        S_PUSH_HI,
        S_PUSH_LO
    } state_t;

    localparam logic [2:0] CMD_INC    = 3'd1;
    localparam logic [2:0] CMD_BRANCH = 3'd2;
    localparam logic [2:0] CMD_JUMP   = 3'd3;
    localparam logic [2:0] CMD_VECTOR = 3'd4;
    localparam logic [2:0] CMD_PUSH   = 3'd5;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  temp_q, temp_d;
    logic [1:0]  vec_sel_q, vec_sel_d;
    logic [7:0]  db_out_q, db_out_d;
    logic        fix_dec_q, fix_dec_d;
    logic        page_cross_q, page_cross_d;
    logic        done_q, done_d;

    logic [15:0] vec_addr;
    logic [8:0]  br_sum;

    always_comb begin
        case (vec_sel_q)
            2'd0:    vec_addr = RESET_VEC;
            2'd1:    vec_addr = NMI_VEC;
            default: vec_addr = IRQ_VEC;
        endcase
    end

    always_comb begin
        case (state_q)
            S_JMP_HI: addr_out = pc_q + 16'd1;
            S_VEC_LO: addr_out = vec_addr;
            S_VEC_HI: addr_out = vec_addr + 16'd1;
            default:  addr_out = pc_q;
        endcase
    end

    // Carry out of the low-byte add decides whether PCH needs a fixup cycle.
    assign br_sum = {1'b0, pc_q[7:0]} + {1'b0, db_in};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        temp_d       = temp_q;
        vec_sel_d    = vec_sel_q;
        db_out_d     = db_out_q;
        fix_dec_d    = fix_dec_q;
        page_cross_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        CMD_INC: begin
                            pc_d   = pc_q + 16'd1;
                            done_d = 1'b1;
                        end
                        CMD_BRANCH: begin
                            pc_d[7:0] = br_sum[7:0];
                            if (!db_in[7] && br_sum[8]) begin
                                fix_dec_d    = 1'b0;
                                page_cross_d = 1'b1;
                                state_d      = S_FIX;
                            end else if (db_in[7] && !br_sum[8]) begin
                                fix_dec_d    = 1'b1;
                                page_cross_d = 1'b1;
                                state_d      = S_FIX;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        CMD_JUMP: begin
                            temp_d  = db_in;
                            state_d = S_JMP_HI;
                        end
                        CMD_VECTOR: begin
                            vec_sel_d = vec_sel;
                            state_d   = S_VEC_LO;
                        end
                        CMD_PUSH: begin
                            db_out_d = pc_q[15:8];
                            state_d  = S_PUSH_HI;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            S_FIX: begin
                pc_d[15:8] = fix_dec_q ? pc_q[15:8] - 8'd1 : pc_q[15:8] + 8'd1;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            S_JMP_HI: begin
                pc_d    = {db_in, temp_q};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_VEC_LO: begin
                temp_d  = db_in;
                state_d = S_VEC_HI;
            end
            S_VEC_HI: begin
                pc_d    = {db_in, temp_q};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_PUSH_HI: begin
                db_out_d = pc_q[7:0];
                state_d  = S_PUSH_LO;
            end
            S_PUSH_LO: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset lands in VEC_LO so the reset vector is fetched as soon as reset_n rises.
    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_VEC_LO;
            pc_q         <= 16'h0000;
            temp_q       <= 8'h00;
            vec_sel_q    <= 2'd0;
            db_out_q     <= 8'h00;
            fix_dec_q    <= 1'b0;
            page_cross_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            temp_q       <= temp_d;
            vec_sel_q    <= vec_sel_d;
            db_out_q     <= db_out_d;
            fix_dec_q    <= fix_dec_d;
            page_cross_q <= page_cross_d;
            done_q       <= done_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign db_we      = (state_q == S_PUSH_HI) || (state_q == S_PUSH_LO);
    assign pc         = pc_q;
    assign db_out     = db_out_q;
    assign page_cross = page_cross_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed-vector bench for pc_sequencer against a byte-array memory
module tb_pc_sequencer;

    logic        fclk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [1:0]  vec_sel;
    logic [7:0]  db_in;
    logic        cmd_ready;
    logic [15:0] pc;
    logic [15:0] addr_out;
    logic [7:0]  db_out;
    logic        db_we;
    logic        page_cross;
    logic        done;

    logic [7:0] mem [0:65535];
    int n_vec = 0;
    int n_bad = 0;

    pc_sequencer dut (
        .fclk       (fclk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .vec_sel    (vec_sel),
        .db_in      (db_in),
        .cmd_ready  (cmd_ready),
        .pc         (pc),
        .addr_out   (addr_out),
        .db_out     (db_out),
        .db_we      (db_we),
        .page_cross (page_cross),
        .done       (done)
    );

    always #5 fclk = ~fclk;

    assign db_in = mem[addr_out];

    task automatic expect_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
        cmd       = 3'd0;
    endtask

    // Load a target through a JUMP using the two bytes at the current pc.
    task automatic jump_to(input logic [15:0] target);
        mem[pc]         = target[7:0];
        mem[pc + 16'd1] = target[15:8];
        issue(3'd3);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        mem[16'hFFFA] = 8'h00;
        mem[16'hFFFB] = 8'h80;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        vec_sel   = 2'd0;
        repeat (2) tick();

        expect_eq("rst_pc", pc, 16'h0000);
        expect_eq("rst_ready", {15'd0, cmd_ready}, 16'd0);
        expect_eq("rst_we", {15'd0, db_we}, 16'd0);
        expect_eq("rst_dbout", {8'd0, db_out}, 16'd0);
        expect_eq("rst_pcross", {15'd0, page_cross}, 16'd0);
        expect_eq("rst_done", {15'd0, done}, 16'd0);

        reset_n = 1'b1;
        expect_eq("rv_addr_lo", addr_out, 16'hFFFC);
        tick();
        expect_eq("rv_addr_hi", addr_out, 16'hFFFD);
        expect_eq("rv_ready_busy", {15'd0, cmd_ready}, 16'd0);
        tick();
        expect_eq("rv_pc", pc, 16'h1234);
        expect_eq("rv_done", {15'd0, done}, 16'd1);
        expect_eq("rv_ready", {15'd0, cmd_ready}, 16'd1);
        tick();
        expect_eq("rv_done_pulse", {15'd0, done}, 16'd0);

        issue(3'd0);
        expect_eq("nop_pc", pc, 16'h1234);
        expect_eq("nop_done", {15'd0, done}, 16'd1);

        jump_to(16'hFFFF);
        expect_eq("jmp_ffff", pc, 16'hFFFF);
        issue(3'd1);
        expect_eq("inc_wrap", pc, 16'h0000);
        expect_eq("inc_done", {15'd0, done}, 16'd1);
        expect_eq("inc_pcross", {15'd0, page_cross}, 16'd0);

        jump_to(16'h1280);
        mem[16'h1280] = 8'h10;
        issue(3'd2);
        expect_eq("br_same_pc", pc, 16'h1290);
        expect_eq("br_same_done", {15'd0, done}, 16'd1);
        expect_eq("br_same_pcross", {15'd0, page_cross}, 16'd0);

        jump_to(16'h12F0);
        mem[16'h12F0] = 8'h20;
        issue(3'd2);
        expect_eq("br_fwd_pc1", pc, 16'h1210);
        expect_eq("br_fwd_pcross", {15'd0, page_cross}, 16'd1);
        expect_eq("br_fwd_done1", {15'd0, done}, 16'd0);
        expect_eq("br_fwd_addr", addr_out, 16'h1210);
        tick();
        expect_eq("br_fwd_pc2", pc, 16'h1310);
        expect_eq("br_fwd_done2", {15'd0, done}, 16'd1);
        expect_eq("br_fwd_pcross2", {15'd0, page_cross}, 16'd0);

        jump_to(16'h1205);
        mem[16'h1205] = 8'hF0;
        issue(3'd2);
        expect_eq("br_back_pc1", pc, 16'h12F5);
        expect_eq("br_back_pcross", {15'd0, page_cross}, 16'd1);
        tick();
        expect_eq("br_back_pc2", pc, 16'h11F5);
        expect_eq("br_back_done", {15'd0, done}, 16'd1);

        jump_to(16'h2000);
        mem[16'h2000] = 8'hCD;
        mem[16'h2001] = 8'hAB;
        issue(3'd3);
        expect_eq("jmp_hi_addr", addr_out, 16'h2001);
        tick();
        expect_eq("jmp_pc", pc, 16'hABCD);
        expect_eq("jmp_done", {15'd0, done}, 16'd1);

        issue(3'd5);
        expect_eq("push_hi_we", {15'd0, db_we}, 16'd1);
        expect_eq("push_hi_db", {8'd0, db_out}, 16'h00AB);
        tick();
        expect_eq("push_lo_we", {15'd0, db_we}, 16'd1);
        expect_eq("push_lo_db", {8'd0, db_out}, 16'h00CD);
        tick();
        expect_eq("push_end_we", {15'd0, db_we}, 16'd0);
        expect_eq("push_done", {15'd0, done}, 16'd1);
        expect_eq("push_pc", pc, 16'hABCD);

        vec_sel = 2'd1;
        issue(3'd4);
        expect_eq("nmi_addr_lo", addr_out, 16'hFFFA);
        tick();
        expect_eq("nmi_addr_hi", addr_out, 16'hFFFB);
        cmd_valid = 1'b1;
        cmd       = 3'd1;
        tick();
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        expect_eq("nmi_pc", pc, 16'h8000);
        expect_eq("nmi_done", {15'd0, done}, 16'd1);
        tick();
        expect_eq("nmi_inc_ignored", pc, 16'h8000);

        issue(3'd5);
        tick();
        expect_eq("rstmid_we_before", {15'd0, db_we}, 16'd1);
        reset_n = 1'b0;
        #1;
        expect_eq("rstmid_we", {15'd0, db_we}, 16'd0);
        expect_eq("rstmid_pc", pc, 16'h0000);
        expect_eq("rstmid_addr", addr_out, 16'hFFFC);
        tick();
        reset_n = 1'b1;
        tick();
        expect_eq("rstmid_addr_hi", addr_out, 16'hFFFD);
        tick();
        expect_eq("rstmid_refetch", pc, 16'h1234);
        expect_eq("rstmid_done", {15'd0, done}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequences the 16-bit program counter (PCL/PCH pair) of the 65C02 core: increment, relative branch, absolute jump, interrupt/reset vector fetch, and PC push to stack.
- Sits between instruction decode and the PC byte registers/address bus.
- Owns the PCH carry-fixup cycle and the multi-cycle vector and push sequences.
- Presents a single command interface to decode.

Parameters:
- RESET_VEC, 16'hFFFC, address of reset vector low byte
- NMI_VEC, 16'hFFFA, address of NMI vector low byte
- IRQ_VEC, 16'hFFFE, address of IRQ/BRK vector low byte

Ports:
- fclk  in  1  core clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request from decode
- cmd  in  3  0 NOP, 1 INC, 2 BRANCH, 3 JUMP, 4 VECTOR, 5 PUSH; 6–7 treated as NOP
- vec_sel  in  2  VECTOR source: 0 reset, 1 NMI, 2 IRQ/BRK, 3 treated as IRQ
- db_in  in  8  data bus in; memory data for addr_out, sampled at the same rising edge
- cmd_ready  out  1  high when IDLE; a command is accepted on cmd_valid && cmd_ready
- pc  out  16  current program counter {PCH, PCL}
- addr_out  out  16  bus address: pc, vector address, or jump-high fetch address
- db_out  out  8  PC byte being pushed
- db_we  out  1  push write strobe
- page_cross  out  1  one-cycle pulse when a branch enters the carry-fixup cycle
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- States: IDLE, FIX, JMP_HI, VEC_LO, VEC_HI, PUSH_HI, PUSH_LO.
- Reset (async, reset_n=0):
  - pc=16'h0000, state=VEC_LO, internal vec_sel=reset.
  - cmd_ready=0, db_we=0, db_out=0, page_cross=0, done=0.
  - On release the reset vector is fetched automatically.
- Reset mid-operation aborts any sequence, discards partial PC bytes and restarts the reset-vector fetch.
- IDLE:
  - addr_out=pc, cmd_ready=1.
  - NOP: no change, done pulses.
  - INC: pc<=pc+1, 16-bit wrap (FFFF->0000), done next cycle, 1 cycle.
  - BRANCH: offset = db_in, signed.
    - PCL<=PCL+offset[7:0].
    - Compute the high-byte adjust: +1 if offset≥0 and carry out; −1 if offset<0 and no carry out; else 0.
    - Adjust 0: done, stay IDLE (1 cycle).
    - Else: go to FIX and pulse page_cross.
  - JUMP: low byte = db_in, latched into temp; go to JMP_HI.
  - VECTOR: latch vec_sel; go to VEC_LO.
  - PUSH: go to PUSH_HI.
- FIX:
  - addr_out=pc (PCL already updated, PCH stale).
  - PCH<=PCH±1 with 8-bit wrap; done; go to IDLE. Total 2 cycles.
- JMP_HI:
  - addr_out=pc+1.
  - pc<={db_in, temp}; done; go to IDLE.
- VEC_LO:
  - addr_out=selected vector address.
  - temp<=db_in; go to VEC_HI.
- VEC_HI:
  - addr_out=vector+1.
  - pc<={db_in, temp}; done; go to IDLE.
- PUSH_HI: db_out=PCH, db_we=1; go to PUSH_LO.
- PUSH_LO: db_out=PCL, db_we=1; done; go to IDLE. pc unchanged. Stack address is owned by the stack pointer block.
- db_we is low in all other states; db_out holds its last value.
- cmd_valid while cmd_ready=0 is ignored, not queued; decode must hold the request.
- page_cross and done are registered single-cycle pulses. They never assert together except on FIX completion, where done=1 and page_cross=0.

Test Plan:
- Reset release; memory FFFC=34, FFFD=12 → addr_out FFFC then FFFD, pc=1234 after 2 cycles, done pulse, cmd_ready=1.
- pc=FFFF, INC → pc=0000 next cycle, done=1, no page_cross.
- Branch cases:
  - pc=1280, BRANCH offset 10 → pc=1290 in 1 cycle.
  - pc=12F0, offset 20 → cycle 1 pc=1210 with page_cross=1, cycle 2 pc=1310, done.
  - pc=1205, offset F0 (−16) → 12F5, then 11F5 after FIX.
- pc=2000, JUMP with db_in=CD then db_in=AB at addr 2001 → pc=ABCD, done. PUSH → db_out AB then CD with db_we=1 two cycles, pc unchanged.
- VECTOR vec_sel=1, mem FFFA=00, FFFB=80 → pc=8000. Assert INC during VEC_HI → ignored, pc unaffected.
- reset_n low during PUSH_LO → db_we drops immediately, pc=0000; after release the reset vector is re-fetched.
